vga_sync_porch: RTL and testbench
=================================

# vga_sync_porch

Downstream companion to the VGA sync-pulse generator. It consumes that generator's active-region HSync/VSync flags and the matching RGB video. It re-derives column/row position from the flag edges and produces standard active-low HSync/VSync pulses, with front and back porch, for the VGA connector. RGB is delayed so that it stays pixel-aligned with the regenerated syncs.

## Interface
Parameters:
- TOTAL_COLS, 800, pixels per line including blanking
- TOTAL_ROWS, 525, lines per frame including blanking
- ACTIVE_COLS, 640, visible pixels per line
- ACTIVE_ROWS, 480, visible lines per frame
- FRONT_PORCH_HORZ, 16, columns between active end and HSync pulse
- BACK_PORCH_HORZ, 48, columns between HSync pulse end and line end
- FRONT_PORCH_VERT, 10, rows between active end and VSync pulse
- BACK_PORCH_VERT, 33, rows between VSync pulse end and frame end
- VIDEO_WIDTH, 3, bits per colour channel

Ports:
- i_Clk  input  1  pixel clock; single clock domain
- i_Rst_L  input  1  asynchronous, active-low reset
- i_HSync  input  1  upstream flag, 1 while upstream column < ACTIVE_COLS
- i_VSync  input  1  upstream flag, 1 while upstream row < ACTIVE_ROWS
- i_Red_Video / i_Grn_Video / i_Blu_Video  input  VIDEO_WIDTH  pixel colour aligned to i_HSync/i_VSync
- o_HSync  output  1  active-low horizontal sync to connector
- o_VSync  output  1  active-low vertical sync to connector
- o_Red_Video / o_Grn_Video / o_Blu_Video  output  VIDEO_WIDTH  delayed colour
- o_Locked  output  1  1 once a frame start has been captured

## Operation
- Frame-start detect: i_HSync=1 and i_VSync=1 while the registered previous i_VSync=0. This marks the upstream sample at column 0, row 0.
- Internal r_Col/r_Row (10 bits each) describe the sample captured at the same edge:
  - Frame start loads r_Col=0, r_Row=0.
  - Otherwise r_Col increments and wraps TOTAL_COLS-1→0.
  - On column wrap, r_Row increments and wraps TOTAL_ROWS-1→0.
- Every detected frame start reloads the counters, including a mid-frame one caused by an upstream glitch. o_Locked stays 1.
- HSync: o_HSync=0 iff r_Col ∈ [ACTIVE_COLS+FRONT_PORCH_HORZ, TOTAL_COLS-BACK_PORCH_HORZ-1]. Defaults give 656..751, 96 columns.
- VSync: o_VSync=0 iff r_Row ∈ [ACTIVE_ROWS+FRONT_PORCH_VERT, TOTAL_ROWS-BACK_PORCH_VERT-1]. Defaults give 490..491.
- Before lock:
  - Counters hold 0.
  - o_HSync=o_VSync=1 (inactive).
  - Video outputs are 0.
- Comparisons are unsigned 10-bit. Parameters must satisfy ACTIVE+FRONT+BACK < TOTAL on each axis; elaboration error otherwise.

## Timing
- Reset (async assert, sync release): o_HSync=1, o_VSync=1, video=0, o_Locked=0, all counters and pipeline registers 0.
- Latency: fixed 2 cycles from i_* to o_* for sync position and video.
  - Stage 1 registers input video and updates the counters.
  - Stage 2 registers the sync compares and video outputs.
- o_Locked rises at stage 2 of the first frame-start sample, the same edge that presents column 0, row 0 at the outputs.
- Reset asserted mid-line returns every output to its reset value immediately. Relock happens at the next upstream frame start.
- A frame start detected in the same cycle as a natural counter wrap resolves to the reload to 0, which gives the same result.

## Configuration
- VGA_PORCH_BLANK_EN defined: stage-2 video is forced to 0 whenever the stage-1 position has r_Col ≥ ACTIVE_COLS or r_Row ≥ ACTIVE_ROWS.
- Not defined: delayed input video passes through unchanged in all regions.

## Structure
- Shared package vga_timing_pkg holds:
  - default 640×480 timing constants: totals, actives, four porches;
  - the counter width (10);
  - the video channel width constant.
- One sub-module: vga_delay_line, a parameterized N-stage, W-bit register pipe with async active-low clear, used for the RGB delay.

## Test plan
- Reset, then drive from the upstream generator: o_Locked=0 until the first frame start, then 1 exactly 2 cycles after the upstream (col 0, row 0) sample.
- Locked run: o_HSync low exactly 96 cycles per 800-cycle line, falling 2 cycles after upstream col 656.
- Locked run: o_VSync low for 1600 consecutive cycles (rows 490–491) per 420000-cycle frame.
- Drive red=3'b111 for one cycle at upstream col 10, row 5; otherwise 0: o_Red_Video=3'b111 for exactly one cycle, 2 cycles later.
- Drive constant all-ones video:
  - With VGA_PORCH_BLANK_EN, output is 0 for cols 640–799 and rows 480–524, and all-ones in the active area.
  - Without it, output is all-ones everywhere after lock.
- Assert i_Rst_L=0 at upstream col 300: o_HSync=1, o_VSync=1, video=0 and o_Locked=0 immediately. After release, o_Locked=1 only after the next frame start.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared timing defaults for the VGA porch regenerator: standard 640x480 totals,
//   active sizes and porches, the position counter width and the colour channel width.
//   Also provides the pos_t counter type and an inclusive window compare helper.
package vga_timing_pkg;

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned VIDEO_W = 3;

    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned V_TOTAL  = 525;
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned H_FRONT  = 16;
    localparam int unsigned H_BACK   = 48;
    localparam int unsigned V_FRONT  = 10;
    localparam int unsigned V_BACK   = 33;

    typedef logic [CNT_W-1:0] pos_t;

    // Unsigned inclusive range test on counter positions.
    function automatic logic in_window(input pos_t pos, input pos_t lo, input pos_t hi);
        return (pos >= lo) && (pos <= hi);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line
//   STAGES-deep, WIDTH-bit register pipe with asynchronous active-low clear.
//   Ports:
//     clk    - clock
//     rst_n  - asynchronous active-low clear of every stage
//     d      - pipe input
//     q      - output of the last stage (d delayed by STAGES cycles)
module vga_delay_line #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned WIDTH  = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q = pipe_q[STAGES-1];

endmodule

// File: rtl/vga_sync_porch.sv
// vga_sync_porch
//   Rebuilds connector-ready active-low HSync/VSync (with front/back porch) from the
//   upstream generator's active-region flags, keeping RGB pixel-aligned. Two-stage
//   pipeline: stage 1 tracks position and registers video, stage 2 registers the sync
//   compares and the output video. Fixed latency of 2 cycles from i_* to o_*.
//   Ports:
//     i_Clk, i_Rst_L            - pixel clock, asynchronous active-low reset
//     i_HSync, i_VSync          - upstream flags, high while column/row is active
//     i_Red/Grn/Blu_Video       - colour aligned with the upstream flags
//     o_HSync, o_VSync          - active-low sync pulses for the connector
//     o_Red/Grn/Blu_Video       - colour delayed to match the syncs
//     o_Locked                  - high once a frame start has been captured
//   Build option: define VGA_PORCH_BLANK_EN to force output video to 0 outside the
//   active area; otherwise delayed video passes through in all regions.
module vga_sync_porch
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL_COLS       = H_TOTAL,
    parameter int unsigned TOTAL_ROWS       = V_TOTAL,
    parameter int unsigned ACTIVE_COLS      = H_ACTIVE,
    parameter int unsigned ACTIVE_ROWS      = V_ACTIVE,
    parameter int unsigned FRONT_PORCH_HORZ = H_FRONT,
    parameter int unsigned BACK_PORCH_HORZ  = H_BACK,
    parameter int unsigned FRONT_PORCH_VERT = V_FRONT,
    parameter int unsigned BACK_PORCH_VERT  = V_BACK,
    parameter int unsigned VIDEO_WIDTH      = VIDEO_W
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    input  logic                   i_HSync,
    input  logic                   i_VSync,
    input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
    input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
    input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
    output logic                   o_HSync,
    output logic                   o_VSync,
    output logic [VIDEO_WIDTH-1:0] o_Red_Video,
    output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
    output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
    output logic                   o_Locked
);

    if (ACTIVE_COLS + FRONT_PORCH_HORZ + BACK_PORCH_HORZ >= TOTAL_COLS) begin : g_bad_horz
        $error("vga_sync_porch: ACTIVE_COLS + porches must be less than TOTAL_COLS");
    end
    if (ACTIVE_ROWS + FRONT_PORCH_VERT + BACK_PORCH_VERT >= TOTAL_ROWS) begin : g_bad_vert
        $error("vga_sync_porch: ACTIVE_ROWS + porches must be less than TOTAL_ROWS");
    end
    if (TOTAL_COLS > 2 ** CNT_W || TOTAL_ROWS > 2 ** CNT_W) begin : g_bad_width
        $error("vga_sync_porch: totals do not fit the position counters");
    end

    localparam int unsigned RGB_W = 3 * VIDEO_WIDTH;

    localparam pos_t COL_LAST = pos_t'(TOTAL_COLS - 1);
    localparam pos_t ROW_LAST = pos_t'(TOTAL_ROWS - 1);
    localparam pos_t HS_FIRST = pos_t'(ACTIVE_COLS + FRONT_PORCH_HORZ);
    localparam pos_t HS_LAST  = pos_t'(TOTAL_COLS - BACK_PORCH_HORZ - 1);
    localparam pos_t VS_FIRST = pos_t'(ACTIVE_ROWS + FRONT_PORCH_VERT);
    localparam pos_t VS_LAST  = pos_t'(TOTAL_ROWS - BACK_PORCH_VERT - 1);

    // Stage 1: position of the sample captured at the same edge.
    logic vsync_prev_q;
    logic locked1_q, locked1_d;
    pos_t col_q, col_d;
    pos_t row_q, row_d;
    logic frame_start;
    logic [RGB_W-1:0] rgb_s1;

    // Stage 2: connector-facing registers.
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             locked2_q;
    logic [RGB_W-1:0] rgb_q, rgb_d;

    // Rising edge of the row flag while the column flag is set: upstream col 0, row 0.
    assign frame_start = i_HSync & i_VSync & ~vsync_prev_q;

    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        locked1_d = locked1_q;
        if (frame_start) begin
            // Reload wins over a coincident natural wrap; both land on 0/0.
            col_d     = '0;
            row_d     = '0;
            locked1_d = 1'b1;
        end else if (locked1_q) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + pos_t'(1);
            end else begin
                col_d = col_q + pos_t'(1);
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            vsync_prev_q <= 1'b0;
            locked1_q    <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
        end else begin
            vsync_prev_q <= i_VSync;
            locked1_q    <= locked1_d;
            col_q        <= col_d;
            row_q        <= row_d;
        end
    end

    vga_delay_line #(
        .STAGES (1),
        .WIDTH  (RGB_W)
    ) u_rgb_stage1 (
        .clk   (i_Clk),
        .rst_n (i_Rst_L),
        .d     ({i_Red_Video, i_Grn_Video, i_Blu_Video}),
        .q     (rgb_s1)
    );

    always_comb begin
        hsync_d = ~(locked1_q & in_window(col_q, HS_FIRST, HS_LAST));
        vsync_d = ~(locked1_q & in_window(row_q, VS_FIRST, VS_LAST));
        rgb_d   = locked1_q ? rgb_s1 : '0;
`ifdef VGA_PORCH_BLANK_EN
        if (col_q >= pos_t'(ACTIVE_COLS) || row_q >= pos_t'(ACTIVE_ROWS)) begin
            rgb_d = '0;
        end
`endif
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            locked2_q <= 1'b0;
            rgb_q     <= '0;
        end else begin
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            locked2_q <= locked1_q;
            rgb_q     <= rgb_d;
        end
    end

    assign o_HSync     = hsync_q;
    assign o_VSync     = vsync_q;
    assign o_Locked    = locked2_q;
    assign o_Red_Video = rgb_q[3*VIDEO_WIDTH-1:2*VIDEO_WIDTH];
    assign o_Grn_Video = rgb_q[2*VIDEO_WIDTH-1:VIDEO_WIDTH];
    assign o_Blu_Video = rgb_q[VIDEO_WIDTH-1:0];

endmodule

// File: tb/tb_vga_sync_porch.sv
// Directed bench for vga_sync_porch using a reduced timing so whole frames fit quickly:
// 20 cols (12 active, porches 2/3 -> HSync low cols 14..16),
// 12 rows (6 active, porches 2/2 -> VSync low rows 8..9). Frame = 240 cycles.
module tb_vga_sync_porch;

    localparam int unsigned TC = 20;
    localparam int unsigned TR = 12;
    localparam int unsigned AC = 12;
    localparam int unsigned AR = 6;

    typedef struct packed {
        logic       valid;
        logic       fs;
        logic [9:0] col;
        logic [9:0] row;
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } smp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       hs_in = 1'b0;
    logic       vs_in = 1'b0;
    logic [2:0] r_in = '0, g_in = '0, b_in = '0;
    logic       o_hs, o_vs, o_lock;
    logic [2:0] o_r, o_g, o_b;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   up_col = 0;
    int   up_row = 0;
    int   vid_mode = 0;
    logic lock_m = 1'b0;
    logic prev_vs_m = 1'b0;
    smp_t p1 = '0, p2 = '0, drv = '0;

    vga_sync_porch #(
        .TOTAL_COLS       (TC),
        .TOTAL_ROWS       (TR),
        .ACTIVE_COLS      (AC),
        .ACTIVE_ROWS      (AR),
        .FRONT_PORCH_HORZ (2),
        .BACK_PORCH_HORZ  (3),
        .FRONT_PORCH_VERT (2),
        .BACK_PORCH_VERT  (2),
        .VIDEO_WIDTH      (3)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_HSync     (hs_in),
        .i_VSync     (vs_in),
        .i_Red_Video (r_in),
        .i_Grn_Video (g_in),
        .i_Blu_Video (b_in),
        .o_HSync     (o_hs),
        .o_VSync     (o_vs),
        .o_Red_Video (o_r),
        .o_Grn_Video (o_g),
        .o_Blu_Video (o_b),
        .o_Locked    (o_lock)
    );

    always #5 clk = ~clk;

    // One clock: check outputs against the sample driven two cycles ago, then drive
    // the next upstream sample.
    task automatic step();
        smp_t        s;
        logic        e_hs, e_vs;
        logic [8:0]  e_rgb;
        logic [11:0] exp_v, got_v;
        @(posedge clk);
        #1;
        cyc++;
        if (p2.valid && p2.fs) lock_m = 1'b1;
        e_hs  = 1'b1;
        e_vs  = 1'b1;
        e_rgb = '0;
        if (lock_m && p2.valid) begin
            e_hs  = !(p2.col >= 14 && p2.col <= 16);
            e_vs  = !(p2.row >= 8 && p2.row <= 9);
            e_rgb = {p2.r, p2.g, p2.b};
`ifdef VGA_PORCH_BLANK_EN
            if (p2.col >= AC || p2.row >= AR) e_rgb = '0;
`endif
        end
        exp_v = {e_hs, e_vs, lock_m, e_rgb};
        got_v = {o_hs, o_vs, o_lock, o_r, o_g, o_b};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL cycle_model cyc=%0d src_col=%0d src_row=%0d got=%b expected=%b",
                     cyc, p2.col, p2.row, got_v, exp_v);
        end
        s.col   = 10'(up_col);
        s.row   = 10'(up_row);
        s.valid = rst_n;
        s.r     = (vid_mode == 1 || (vid_mode == 2 && up_col == 10 && up_row == 5)) ?
                  3'b111 : 3'b000;
        s.g     = (vid_mode == 1) ? 3'b111 : 3'b000;
        s.b     = (vid_mode == 1) ? 3'b111 : 3'b000;
        s.fs    = s.valid && (up_col < AC) && (up_row < AR) && !prev_vs_m;
        prev_vs_m = s.valid && (up_row < AR);
        hs_in = (up_col < AC);
        vs_in = (up_row < AR);
        r_in  = s.r;
        g_in  = s.g;
        b_in  = s.b;
        p2  = p1;
        p1  = s;
        drv = s;
        up_col++;
        if (up_col == TC) begin
            up_col = 0;
            up_row = (up_row + 1) % TR;
        end
    endtask

    task automatic assert_reset(input string name);
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_hs !== 1'b1) begin
            errors++;
            $display("FAIL %s_hsync got=%b expected=1", name, o_hs);
        end
        checks++;
        if (o_vs !== 1'b1) begin
            errors++;
            $display("FAIL %s_vsync got=%b expected=1", name, o_vs);
        end
        checks++;
        if (o_lock !== 1'b0) begin
            errors++;
            $display("FAIL %s_locked got=%b expected=0", name, o_lock);
        end
        checks++;
        if ({o_r, o_g, o_b} !== 9'd0) begin
            errors++;
            $display("FAIL %s_video got=%b expected=0", name, {o_r, o_g, o_b});
        end
        lock_m    = 1'b0;
        prev_vs_m = 1'b0;
        p1.valid  = 1'b0;
        p2.valid  = 1'b0;
    endtask

    // The sample on the inputs now is captured at the next edge with a cleared
    // previous-VSync register.
    task automatic release_reset();
        rst_n     = 1'b1;
        p1.valid  = 1'b1;
        p1.fs     = hs_in && vs_in;
        prev_vs_m = vs_in;
    endtask

    task automatic wait_for(input int col, input int row);
        bit found = 0;
        for (int i = 0; i < 600 && !found; i++) begin
            step();
            if (drv.col == 10'(col) && drv.row == 10'(row)) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_position got=timeout expected=col%0d_row%0d", col, row);
        end
    endtask

    task automatic measure_lock(input string name);
        int fs_cyc = -1;
        int lk_cyc = -1;
        for (int i = 0; i < 400 && lk_cyc < 0; i++) begin
            step();
            if (drv.fs && fs_cyc < 0) fs_cyc = cyc;
            if (o_lock === 1'b1) lk_cyc = cyc;
        end
        checks++;
        if (lk_cyc < 0 || fs_cyc < 0 || lk_cyc - fs_cyc != 2) begin
            errors++;
            $display("FAIL %s_latency got=%0d expected=2 (fs_cyc=%0d lock_cyc=%0d)",
                     name, lk_cyc - fs_cyc, fs_cyc, lk_cyc);
        end
    endtask

    task automatic test_reset();
        #2;
        assert_reset("reset");
        up_col = 0;
        up_row = 10;
        step();
        step();
        release_reset();
    endtask

    task automatic test_lock();
        measure_lock("lock");
    endtask

    task automatic test_hsync();
        int   low = 0;
        int   fall = -1;
        int   c14 = -1;
        logic prev;
        wait_for(0, 3);
        prev = o_hs;
        for (int i = 0; i < 22; i++) begin
            step();
            if (drv.col == 10'd14 && c14 < 0) c14 = cyc;
            if (i < 20 && o_hs === 1'b0) low++;
            if (prev === 1'b1 && o_hs === 1'b0 && fall < 0) fall = cyc;
            prev = o_hs;
        end
        checks++;
        if (low != 3) begin
            errors++;
            $display("FAIL hsync_width got=%0d expected=3", low);
        end
        checks++;
        if (fall < 0 || fall - c14 != 2) begin
            errors++;
            $display("FAIL hsync_fall_offset got=%0d expected=2", fall - c14);
        end
    endtask

    task automatic test_vsync();
        int low = 0;
        int run = 0;
        int max_run = 0;
        wait_for(0, 0);
        for (int i = 0; i < 240; i++) begin
            step();
            if (o_vs === 1'b0) begin
                low++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
        checks++;
        if (low != 40) begin
            errors++;
            $display("FAIL vsync_total got=%0d expected=40", low);
        end
        checks++;
        if (max_run != 40) begin
            errors++;
            $display("FAIL vsync_run got=%0d expected=40", max_run);
        end
    endtask

    task automatic test_pixel();
        int n = 0;
        int pc = -1;
        int rc = -1;
        vid_mode = 2;
        wait_for(0, 0);
        for (int i = 0; i < 240; i++) begin
            step();
            if (drv.col == 10'd10 && drv.row == 10'd5) pc = cyc;
            if (o_r === 3'b111) begin
                n++;
                rc = cyc;
            end
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL pixel_count got=%0d expected=1", n);
        end
        checks++;
        if (rc - pc != 2) begin
            errors++;
            $display("FAIL pixel_offset got=%0d expected=2", rc - pc);
        end
    endtask

    task automatic test_video_ones();
        int ones = 0;
        int zeros = 0;
        int exp_ones;
`ifdef VGA_PORCH_BLANK_EN
        exp_ones = 72;
`else
        exp_ones = 240;
`endif
        vid_mode = 1;
        wait_for(0, 0);
        for (int i = 0; i < 240; i++) begin
            step();
            if ({o_r, o_g, o_b} === 9'h1ff) ones++;
            if ({o_r, o_g, o_b} === 9'h000) zeros++;
        end
        checks++;
        if (ones != exp_ones) begin
            errors++;
            $display("FAIL ones_active got=%0d expected=%0d", ones, exp_ones);
        end
        checks++;
        if (zeros != 240 - exp_ones) begin
            errors++;
            $display("FAIL ones_blanked got=%0d expected=%0d", zeros, 240 - exp_ones);
        end
        vid_mode = 0;
    endtask

    // Upstream glitch: jump from a blank row straight to col 0, row 0.
    task automatic test_resync();
        wait_for(3, 7);
        up_col = 0;
        up_row = 0;
        for (int i = 0; i < 17; i++) step();
        checks++;
        if (o_hs !== 1'b0) begin
            errors++;
            $display("FAIL resync_hsync got=%b expected=0", o_hs);
        end
        checks++;
        if (o_lock !== 1'b1) begin
            errors++;
            $display("FAIL resync_locked got=%b expected=1", o_lock);
        end
    endtask

    task automatic test_mid_reset();
        wait_for(7, 9);
        assert_reset("midreset");
        for (int i = 0; i < 3; i++) step();
        release_reset();
        measure_lock("relock");
    endtask

    initial begin
        test_reset();
        test_lock();
        test_hsync();
        test_vsync();
        test_pixel();
        test_video_ones();
        test_resync();
        test_mid_reset();
        for (int i = 0; i < 40; i++) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
